// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the sequencer state encoding and the requester IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_PERI = 1'b1;

  // Wide enough for RD_LAT-1 with RD_LAT up to 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-request round-robin picker.
// On a tie the port that did not win last time is chosen.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = ~last_owner;
    end else if (req[1]) begin
      winner = PORT_PERI;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU datapath (port 0) and the
// peripheral/loader master (port 1) with round-robin issue/wait/response sequencing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  arb_state_e        state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              last_owner_reg, last_owner_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] m0_rdata_reg, m1_rdata_reg;
  logic              capture;
  logic              arb_winner, arb_any;
  logic [1:0]        gnt_vec, rvalid_vec;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner_reg),
    .winner     (arb_winner),
    .any        (arb_any)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg      <= IDLE;
      owner_reg      <= PORT_CPU;
      last_owner_reg <= PORT_PERI;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      m0_rdata_reg   <= '0;
      m1_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      cnt_reg        <= cnt_next;
      if (capture && owner_reg == PORT_CPU) begin
        m0_rdata_reg <= mem_rdata;
      end
      if (capture && owner_reg == PORT_PERI) begin
        m1_rdata_reg <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    cnt_next        = cnt_reg;
    capture         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          owner_next      = arb_winner;
          last_owner_next = arb_winner;
          we_next         = (arb_winner == PORT_PERI) ? m1_we    : m0_we;
          addr_next       = (arb_winner == PORT_PERI) ? m1_addr  : m0_addr;
          wdata_next      = (arb_winner == PORT_PERI) ? m1_wdata : m0_wdata;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          state_next = IDLE;
        end else begin
          cnt_next   = CNT_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-port strobes decode straight from the registered state and owner.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT_ID = (gi == 1) ? PORT_PERI : PORT_CPU;
      assign gnt_vec[gi]    = (state_reg == ISSUE) && (owner_reg == PORT_ID);
      assign rvalid_vec[gi] = (state_reg == RESP)  && (owner_reg == PORT_ID);
    end
  endgenerate

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];
  assign m0_rdata  = m0_rdata_reg;
  assign m1_rdata  = m1_rdata_reg;

  assign mem_en    = (state_reg == ISSUE);
  assign mem_we    = mem_en & we_reg;
  assign mem_addr  = mem_en ? addr_reg  : '0;
  assign mem_wdata = mem_en ? wdata_reg : '0;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters.
  - Port 0: the multicycle control FSM / datapath, which uses IorD-muxed addressing.
  - Port 1: the peripheral/loader master, selected when IntorPeri is active.
- Two-way round-robin arbitration.
- Sequences each memory transaction through issue, read-latency wait and response phases.
- Returns read data to the winning requester with a one-cycle valid strobe.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..7.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset, synchronous, active-high.
- m0_req  in  1  port 0 request; held high until m0_gnt.
- m0_we  in  1  port 0 write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 grant, one-cycle pulse.
- m0_rvalid  out  1  port 0 read data valid, one-cycle pulse.
- m0_rdata  out  DATA_W  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid RD_LAT cycles after the mem_en cycle.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (CLR=1 at a CLK edge):
  - State goes to IDLE; last_owner=1; wait counter=0.
  - All outputs go to 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata registers, busy.
  - An in-flight transaction is discarded; no rvalid is ever produced for it.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from registered state/latches.
- IDLE:
  - Arbitration when at least one req is high:
    - Single requester: that port wins.
    - Both requesting: the port != last_owner wins.
  - On the transition, latch owner, we, addr and wdata from the winning port, set last_owner=owner, and go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we=latched we; mem_addr and mem_wdata from latches.
  - Owner gnt=1 for this cycle only.
  - Write: next state is IDLE.
  - Read: load counter=RD_LAT-1, next state is WAIT.
- WAIT:
  - mem_en=0.
  - When counter==0, capture mem_rdata into the owner's rdata register and go to RESP; otherwise decrement the counter.
- RESP (1 cycle): owner rvalid=1, then go to IDLE.
- rdata holds its value until the next read for that port completes.
- Timing, with the request sampled in IDLE at cycle 0:
  - gnt and mem_en at cycle 1.
  - Read: rvalid at cycle RD_LAT+2.
  - Occupancy: write = 2 cycles, read = RD_LAT+3 cycles.
  - Back-to-back transactions always pass through IDLE.
- Fairness: under continuous contention, grants strictly alternate m0, m1, m0, and so on. After reset, m0 wins the first tie.
- A requester that drops req after the IDLE sample still has its latched transaction executed.
- The non-owner never sees gnt or rvalid.
- A request arriving while busy waits in its port until IDLE; it is never lost as long as req stays held.
- Address and data outputs return to 0 in IDLE. mem_we is 0 whenever mem_en=0.

Decomposition:
- Shared include mem_arb_pkg.vh, included like opp_codes_pkg.vh, containing:
  - state encodings IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11;
  - requester IDs PORT_CPU=1'b0, PORT_PERI=1'b1.
- One sub-module, rr_arb2: combinational two-request round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: winner, any.

Test Plan:
- m0 write addr 0x10, data 0xDEADBEEF, m1 idle -> cycle 1: m0_gnt=1, mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle 2: busy=0.
- RD_LAT=1, m1 read addr 0x20, memory returns 0x12345678 -> m1_gnt at cycle 1, m1_rvalid at cycle 3 with m1_rdata=0x12345678; m0_gnt and m0_rvalid never asserted.
- Both ports request reads continuously from reset -> grant order m0, m1, m0, m1; each grant separated by RD_LAT+3 cycles.
- CLR=1 during WAIT of an m0 read -> next cycle busy=0 and mem_en=0; m0_rvalid never pulses; first grant after reset goes to m0 on a tie.
- RD_LAT=3, m0 read -> mem_en only at cycle 1; rdata captured from mem_rdata at cycle 4; m0_rvalid at cycle 5.
- m1 drops req one cycle after the IDLE sample -> transaction still issues, and m1_gnt pulses at cycle 1.
